sdram_req_bridge: RTL and testbench

Multi-channel bridge between byte-wide CPU/peripheral memory strobes and a single toggle-handshake SDRAM controller port. It generalises the core's single-CPU request generator. Each of `NUM_CH` channels gets its own SDRAM region, access-event detection and read-data holding register. Pending accesses are served round-robin. It sits in the core top level on the SDRAM clock, between the machine core (plus future tape/DMA masters) and `sdram` port1.

---
 rtl/sdram_req_bridge_pkg.sv | 21 ++
 rtl/sdram_req_bridge_if.sv | 23 ++
 rtl/sdram_req_bridge_rr_arbiter.sv | 34 +++
 rtl/sdram_req_bridge.sv | 175 +++++++++++++++++
 tb/tb_sdram_req_bridge.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_req_bridge_pkg.sv
// sdram_bridge_pkg: shared types and constants for the multi-channel SDRAM
// request bridge.
//   bridge_state_t : arbiter FSM states (IDLE, WAIT)
//   DS_*           : byte-enable encodings driven on mem_ds
//   chsel_w(n)     : width of the channel-select field for n channels (min 1)
package sdram_bridge_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } bridge_state_t;

   localparam logic [1:0] DS_LO   = 2'b01;
   localparam logic [1:0] DS_HI   = 2'b10;
   localparam logic [1:0] DS_WORD = 2'b11;

   function automatic int chsel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sdram_req_bridge_if.sv
// sdram_req_bridge_if: toggle-handshake port towards the SDRAM controller.
//   req : toggle request (bridge -> controller)
//   ack : toggle acknowledge, transaction done when ack == req
//   a   : byte address {channel, channel address}
//   we  : write strobe
//   ds  : byte enables
//   d   : write word (byte replicated)
//   q   : read word, valid once ack matches req
interface sdram_req_bridge_if #(
   parameter int AW = 16,
   parameter int CW = 1
);
   logic                 req;
   logic                 ack;
   logic [CW+AW-1:0]     a;
   logic                 we;
   logic [1:0]           ds;
   logic [15:0]          d;
   logic [15:0]          q;

   modport master (output req, a, we, ds, d, input ack, q);
   modport slave  (input req, a, we, ds, d, output ack, q);
endinterface

// File: rtl/sdram_req_bridge_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   pend        : request bits, one per channel
//   last        : index of the most recently granted channel
//   grant_valid : at least one request is set
//   grant_idx   : first set bit searching from last+1 modulo N
module rr_arbiter
   import sdram_bridge_pkg::*;
#(
   parameter  int N = 2,
   localparam int W = chsel_w(N)
) (
   input  logic [N-1:0] pend,
   input  logic [W-1:0] last,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx
);

   always_comb begin
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      // Scan from the farthest candidate back to the nearest so the
      // nearest set bit after 'last' is the one left standing.
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last) + k) % N;
         if (pend[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = W'(idx);
         end
      end
   end

endmodule

// File: rtl/sdram_req_bridge.sv
// sdram_req_bridge: NUM_CH byte-wide strobe channels multiplexed onto one
// toggle-handshake SDRAM port, served round-robin, one access in flight.
//   clk, res_n          : SDRAM clock, async active-low reset
//   ch_cs/ch_oe/ch_we   : per-channel select / read / write strobes
//   ch_a, ch_d          : per-channel byte address and write byte (flat)
//   ch_q                : per-channel last read byte, held between reads
//   ch_busy             : channel has a pending or in-flight access
//   mem                 : controller port (see sdram_req_bridge_if)
module sdram_req_bridge
   import sdram_bridge_pkg::*;
#(
   parameter  int NUM_CH = 2,
   parameter  int AW     = 16,
   localparam int CW     = chsel_w(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic [NUM_CH-1:0]    ch_cs,
   input  logic [NUM_CH-1:0]    ch_oe,
   input  logic [NUM_CH-1:0]    ch_we,
   input  logic [NUM_CH*AW-1:0] ch_a,
   input  logic [NUM_CH*8-1:0]  ch_d,
   output logic [NUM_CH*8-1:0]  ch_q,
   output logic [NUM_CH-1:0]    ch_busy,
   sdram_req_bridge_if.master   mem
);

   bridge_state_t                  state_q, state_d;
   logic [NUM_CH-1:0]              pend_q, pend_d;
   logic [NUM_CH-1:0][AW-1:0]      pa_q, pa_d;
   logic [NUM_CH-1:0]              pwe_q, pwe_d;
   logic [NUM_CH-1:0][7:0]         pd_q, pd_d;
   logic [CW-1:0]                  last_q, last_d;
   logic [CW-1:0]                  inflight_q, inflight_d;
   logic                           req_q, req_d;
   logic [CW+AW-1:0]               a_q, a_d;
   logic                           we_q, we_d;
   logic [1:0]                     ds_q, ds_d;
   logic [15:0]                    d_q, d_d;
   logic [NUM_CH-1:0][7:0]         chq_q, chq_d;
   logic [NUM_CH-1:0]              prev_rd_q, prev_wr_q;
   logic [NUM_CH-1:0][AW-1:0]      prev_a_q;

   logic [NUM_CH-1:0]              rd_now, wr_now, ev;
   logic                           grant_valid;
   logic [CW-1:0]                  grant_idx;

   assign rd_now = ch_cs & ch_oe;
   assign wr_now = ch_cs & ch_we;

   // An access event: a new read or write strobe, or the read address
   // moving while the read strobe stays asserted.
   always_comb begin
      ev = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ev[i] = (rd_now[i] & ~prev_rd_q[i]) | (wr_now[i] & ~prev_wr_q[i]) |
                 (rd_now[i] & (ch_a[i*AW +: AW] != prev_a_q[i]));
      end
   end

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .pend        (pend_q),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pa_d       = pa_q;
      pwe_d      = pwe_q;
      pd_d       = pd_q;
      last_d     = last_q;
      inflight_d = inflight_q;
      req_d      = req_q;
      a_d        = a_q;
      we_d       = we_q;
      ds_d       = ds_q;
      d_d        = d_q;
      chq_d      = chq_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               req_d              = ~req_q;
               a_d                = {grant_idx, pa_q[grant_idx]};
               we_d               = pwe_q[grant_idx];
               d_d                = {pd_q[grant_idx], pd_q[grant_idx]};
               ds_d               = pwe_q[grant_idx] ?
                                    (pa_q[grant_idx][0] ? DS_HI : DS_LO) : DS_WORD;
               pend_d[grant_idx]  = 1'b0;
               last_d             = grant_idx;
               inflight_d         = grant_idx;
               state_d            = WAIT;
            end
         end
         WAIT: begin
            // The issued address/we stay on the port until the next issue,
            // so they still describe the in-flight access here even if the
            // channel has since latched a newer pending access.
            if (mem.ack == req_q) begin
               if (!we_q) begin
                  chq_d[inflight_q] = a_q[0] ? mem.q[15:8] : mem.q[7:0];
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Applied after the grant clear so a same-edge event keeps pend set.
      for (int i = 0; i < NUM_CH; i++) begin
         if (ev[i]) begin
            pend_d[i] = 1'b1;
            pa_d[i]   = ch_a[i*AW +: AW];
            pwe_d[i]  = ch_we[i];
            pd_d[i]   = ch_d[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         pa_q       <= '0;
         pwe_q      <= '0;
         pd_q       <= '0;
         last_q     <= CW'(NUM_CH - 1);
         inflight_q <= '0;
         req_q      <= 1'b0;
         a_q        <= '0;
         we_q       <= 1'b0;
         ds_q       <= DS_WORD;
         d_q        <= '0;
         chq_q      <= '0;
         prev_rd_q  <= '0;
         prev_wr_q  <= '0;
         prev_a_q   <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pa_q       <= pa_d;
         pwe_q      <= pwe_d;
         pd_q       <= pd_d;
         last_q     <= last_d;
         inflight_q <= inflight_d;
         req_q      <= req_d;
         a_q        <= a_d;
         we_q       <= we_d;
         ds_q       <= ds_d;
         d_q        <= d_d;
         chq_q      <= chq_d;
         prev_rd_q  <= rd_now;
         prev_wr_q  <= wr_now;
         prev_a_q   <= ch_a;
      end
   end

   always_comb begin
      ch_busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_busy[i] = pend_q[i] | ((state_q == WAIT) && (inflight_q == CW'(i)));
      end
   end

   assign ch_q    = chq_q;
   assign mem.req = req_q;
   assign mem.a   = a_q;
   assign mem.we  = we_q;
   assign mem.ds  = ds_q;
   assign mem.d   = d_q;

endmodule

// File: tb/tb_sdram_req_bridge.sv
// tb_sdram_req_bridge: directed vector table plus hand-written sequences
// for round-robin, latest-wins, same-edge event/grant and reset mid-WAIT.
module tb_sdram_req_bridge;
   import sdram_bridge_pkg::*;

   localparam int NUM_CH = 2;
   localparam int AW     = 16;
   localparam int CW     = 1;
   localparam int LAT    = 4;

   logic                 clk = 1'b0;
   logic                 res_n;
   logic [NUM_CH-1:0]    ch_cs, ch_oe, ch_we;
   logic [NUM_CH*AW-1:0] ch_a;
   logic [NUM_CH*8-1:0]  ch_d;
   logic [NUM_CH*8-1:0]  ch_q;
   logic [NUM_CH-1:0]    ch_busy;

   sdram_req_bridge_if #(.AW(AW), .CW(CW)) mem_if ();

   sdram_req_bridge #(.NUM_CH(NUM_CH), .AW(AW)) dut (
      .clk     (clk),
      .res_n   (res_n),
      .ch_cs   (ch_cs),
      .ch_oe   (ch_oe),
      .ch_we   (ch_we),
      .ch_a    (ch_a),
      .ch_d    (ch_d),
      .ch_q    (ch_q),
      .ch_busy (ch_busy),
      .mem     (mem_if)
   );

   always #5 clk = ~clk;

   // Controller model: acknowledges each request toggle LAT clocks later,
   // and keeps delivering an acknowledge that was pending across a reset.
   logic [15:0]     rsp;
   logic            m_prev, m_pend, m_tgt, m_init = 1'b0;
   int              m_cnt;
   logic [CW+AW-1:0] log_a[$];

   always @(negedge clk) begin
      if (!m_init) begin
         mem_if.ack = 1'b0;
         mem_if.q   = 16'h0;
         m_prev     = 1'b0;
         m_pend     = 1'b0;
         m_tgt      = 1'b0;
         m_cnt      = 0;
         m_init     = 1'b1;
      end
      if (m_pend) begin
         m_cnt++;
         if (m_cnt >= LAT) begin
            mem_if.ack = m_tgt;
            mem_if.q   = rsp;
            m_pend     = 1'b0;
         end
      end
      if (!res_n) begin
         m_prev = mem_if.req;
      end else if (mem_if.req !== m_prev) begin
         m_prev = mem_if.req;
         m_tgt  = mem_if.req;
         m_pend = 1'b1;
         m_cnt  = 0;
         log_a.push_back(mem_if.a);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic cs, input logic oe, input logic we,
                         input logic [AW-1:0] a, input logic [7:0] d);
      ch_cs[ch]         = cs;
      ch_oe[ch]         = oe;
      ch_we[ch]         = we;
      ch_a[ch*AW +: AW] = a;
      ch_d[ch*8 +: 8]   = d;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (ch_busy != '0 && k < budget) begin
         tick(1);
         k++;
      end
      check(name, 32'(ch_busy), 32'h0);
   endtask

   task automatic check_log(input string name, input int i, input logic [CW+AW-1:0] exp);
      logic [CW+AW-1:0] v;
      v = (i < log_a.size()) ? log_a[i] : 'x;
      check(name, 32'(v), 32'(exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " mem_req"},  32'(mem_if.req), 32'h0);
      check({tag, " mem_we"},   32'(mem_if.we),  32'h0);
      check({tag, " mem_ds"},   32'(mem_if.ds),  32'(DS_WORD));
      check({tag, " mem_a"},    32'(mem_if.a),   32'h0);
      check({tag, " mem_d"},    32'(mem_if.d),   32'h0);
      check({tag, " ch_q"},     32'(ch_q),       32'h0);
      check({tag, " ch_busy"},  32'(ch_busy),    32'h0);
   endtask

   typedef struct {
      int          ch;
      logic        oe;
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      logic [15:0] rsp;
      logic [16:0] ea;
      logic        ewe;
      logic [1:0]  eds;
      logic [15:0] ed;
      logic [7:0]  eq;
   } vec_t;

   vec_t vt[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic prev_req, exp_req;
      int   k;

      vt[0] = '{0, 1'b1, 1'b0, 16'h1235, 8'h00, 16'hBEEF, 17'h01235, 1'b0, 2'b11, 16'h0000, 8'hBE};
      vt[1] = '{1, 1'b0, 1'b1, 16'h0010, 8'h5A, 16'h0000, 17'h10010, 1'b1, 2'b01, 16'h5A5A, 8'h00};
      vt[2] = '{0, 1'b1, 1'b0, 16'hFFFE, 8'h00, 16'hA55A, 17'h0FFFE, 1'b0, 2'b11, 16'h0000, 8'h5A};
      vt[3] = '{0, 1'b0, 1'b1, 16'h0001, 8'hFF, 16'h0000, 17'h00001, 1'b1, 2'b10, 16'hFFFF, 8'h5A};
      vt[4] = '{1, 1'b1, 1'b0, 16'h0011, 8'h00, 16'h1234, 17'h10011, 1'b0, 2'b11, 16'h0000, 8'h12};
      vt[5] = '{1, 1'b0, 1'b1, 16'h0013, 8'hC3, 16'h0000, 17'h10013, 1'b1, 2'b10, 16'hC3C3, 8'h12};

      res_n = 1'b0;
      ch_cs = '0; ch_oe = '0; ch_we = '0; ch_a = '0; ch_d = '0;
      rsp   = 16'h0;
      tick(3);
      check_reset_outputs("reset");
      res_n = 1'b1;
      tick(2);

      // Table: one access per row, issued from IDLE.
      for (int i = 0; i < 6; i++) begin
         rsp = vt[i].rsp;
         log_a.delete();
         prev_req = mem_if.req;
         exp_req  = ~prev_req;
         set_ch(vt[i].ch, 1'b1, vt[i].oe, vt[i].we, vt[i].a, vt[i].d);
         tick(1);
         check($sformatf("v%0d no issue at 1 clk", i), 32'(mem_if.req), 32'(prev_req));
         tick(1);
         check($sformatf("v%0d issue at 2 clk", i), 32'(mem_if.req), 32'(exp_req));
         check($sformatf("v%0d mem_a", i),  32'(mem_if.a),  32'(vt[i].ea));
         check($sformatf("v%0d mem_we", i), 32'(mem_if.we), 32'(vt[i].ewe));
         check($sformatf("v%0d mem_ds", i), 32'(mem_if.ds), 32'(vt[i].eds));
         check($sformatf("v%0d mem_d", i),  32'(mem_if.d),  32'(vt[i].ed));
         wait_idle($sformatf("v%0d complete", i), 20);
         set_ch(vt[i].ch, 1'b0, 1'b0, 1'b0, vt[i].a, vt[i].d);
         check($sformatf("v%0d ch_q", i), 32'(ch_q[vt[i].ch*8 +: 8]), 32'(vt[i].eq));
         tick(1);
      end

      // Round-robin: both channels at once after ch1 was served last,
      // then both again while ch0 is in flight.
      log_a.delete();
      rsp = 16'h3C0F;
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0200, 8'h00);
      set_ch(1, 1'b1, 1'b1, 1'b0, 16'h0300, 8'h00);
      tick(2);
      check("rr first grant ch0", 32'(mem_if.a), 32'h00200);
      tick(1);
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0204, 8'h00);
      set_ch(1, 1'b1, 1'b1, 1'b0, 16'h0304, 8'h00);
      tick(1);
      wait_idle("rr complete", 60);
      check("rr request count", 32'(log_a.size()), 32'd3);
      check_log("rr req0", 0, 17'h00200);
      check_log("rr req1 ch1 first", 1, 17'h10304);
      check_log("rr req2", 2, 17'h00204);
      check("rr ch_q0", 32'(ch_q[7:0]),  32'h0F);
      check("rr ch_q1", 32'(ch_q[15:8]), 32'h0F);
      set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0204, 8'h00);
      set_ch(1, 1'b0, 1'b0, 1'b0, 16'h0304, 8'h00);
      tick(1);

      // Latest wins: two ch0 events while ch1 is in flight.
      log_a.delete();
      rsp = 16'h5511;
      set_ch(1, 1'b1, 1'b1, 1'b0, 16'h0400, 8'h00);
      tick(2);
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
      tick(1);
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0101, 8'h00);
      tick(1);
      wait_idle("lw complete", 60);
      check("lw request count", 32'(log_a.size()), 32'd2);
      check_log("lw req0 ch1", 0, 17'h10400);
      check_log("lw req1 latest ch0", 1, 17'h00101);
      check("lw ch_q0", 32'(ch_q[7:0]),  32'h55);
      check("lw ch_q1", 32'(ch_q[15:8]), 32'h11);
      set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0101, 8'h00);
      set_ch(1, 1'b0, 1'b0, 1'b0, 16'h0400, 8'h00);
      tick(1);

      // Event on ch0 in the very edge ch0 is granted.
      log_a.delete();
      rsp = 16'h9966;
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0500, 8'h00);
      tick(1);
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0501, 8'h00);
      tick(1);
      check("own grant busy", 32'(ch_busy[0]), 32'h1);
      k = 0;
      while (ch_busy[0] && k < 60) begin
         tick(1);
         k++;
      end
      check("own requests before busy drop", 32'(log_a.size()), 32'd2);
      check_log("own req0", 0, 17'h00500);
      check_log("own req1", 1, 17'h00501);
      check("own ch_q0", 32'(ch_q[7:0]), 32'h99);
      set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0501, 8'h00);
      tick(1);

      // Reset mid-WAIT. Make the aborted request a 1->0 toggle so the
      // stale acknowledge lands as equality while IDLE.
      if (mem_if.req == 1'b0) begin
         set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0002, 8'h00);
         tick(2);
         wait_idle("rst prep complete", 20);
         set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0002, 8'h00);
         tick(1);
      end
      rsp = 16'h7777;
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0600, 8'h00);
      tick(2);
      check("rst aborted issue", 32'(mem_if.a), 32'h00600);
      tick(1);
      #2;
      res_n = 1'b0;
      #1;
      check_reset_outputs("mid-wait reset");
      ch_cs = '0; ch_oe = '0; ch_we = '0;
      tick(2);
      res_n = 1'b1;
      tick(8);
      check("rst stale ack no ch_q write", 32'(ch_q), 32'h0);
      check("rst stale ack not busy", 32'(ch_busy), 32'h0);
      rsp = 16'hABCD;
      set_ch(0, 1'b1, 1'b1, 1'b0, 16'h0701, 8'h00);
      tick(2);
      check("rst new issue req", 32'(mem_if.req), 32'h1);
      check("rst new issue a", 32'(mem_if.a), 32'h00701);
      wait_idle("rst new complete", 20);
      check("rst new ch_q0", 32'(ch_q[7:0]), 32'hAB);
      set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0701, 8'h00);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
